// File: rtl/lif_sched_pkg.sv
// Shared types and width helpers for the LIF scheduler.
// Holds the FSM state encoding and the default job geometry.
package lif_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_t;

    localparam int unsigned DefN = 4;
    localparam int unsigned DefT = 4;
    localparam int unsigned DefQ = 8;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned t);
        return $clog2(t + 1);
    endfunction

    localparam int unsigned DefIdW  = id_width(DefN);
    localparam int unsigned DefCntW = cnt_width(DefT);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// Produces a one-hot grant, its encoded index and an any-request flag.
module rr_arbiter
    import lif_sched_pkg::*;
#(
    parameter int unsigned N = DefN,
    localparam int unsigned IdW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IdW-1:0] idx,
    output logic           any
);

    always_comb begin
        logic [IdW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdW'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/lif_scheduler.sv
// Shares one LIF datapath among N requesters: round-robin accept, start/done
// handshake with a watchdog, and a valid/ready response carrying the spike train.
module lif_scheduler
    import lif_sched_pkg::*;
#(
    parameter int unsigned N       = DefN,
    parameter int unsigned T       = DefT,
    parameter int unsigned Q       = DefQ,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned IdW    = id_width(N),
    localparam int unsigned CntW   = cnt_width(T)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*T*Q-1:0] req_data,
    input  logic [Q-1:0]     cfg_threshold,
    output logic             lif_start,
    output logic             lif_result_val,
    output logic [T*Q-1:0]   lif_input_data,
    output logic [Q-1:0]     lif_threshold,
    input  logic [T-1:0]     lif_spike_out,
    input  logic             lif_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IdW-1:0]   rsp_id,
    output logic [T-1:0]     rsp_spikes,
    output logic [CntW-1:0]  rsp_spike_cnt,
    output logic             rsp_err,
    output logic             busy,
    output logic [15:0]      job_count
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    state_t state_q, state_d;

    logic [IdW-1:0] rr_ptr_q;
    logic [T*Q-1:0] data_q;
    logic [Q-1:0]   thr_q;
    logic [IdW-1:0] id_q;
    logic [T-1:0]   spikes_q;
    logic           err_q;
    logic [15:0]    job_q;
    logic [WdW-1:0] wd_q;

    logic [N-1:0]   gnt;
    logic [IdW-1:0] gnt_idx;
    logic           gnt_any;

    logic accept;
    logic timeout;
    logic rsp_fire;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign req_ready = (state_q == StIdle) ? gnt : '0;
    assign accept    = (state_q == StIdle) && gnt_any;
    // wd_q counts completed WAIT cycles, so wd_q+1 is the count including this one.
    assign timeout   = (state_q == StWait) && (wd_q == WdW'(TIMEOUT - 1));
    assign rsp_fire  = (state_q == StResp) && rsp_ready;

    always_comb begin
        state_d        = state_q;
        lif_start      = 1'b0;
        lif_result_val = 1'b0;
        rsp_valid      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) state_d = StIssue;
            end
            StIssue: begin
                lif_start      = 1'b1;
                lif_result_val = 1'b1;
                state_d        = StWait;
            end
            StWait: begin
                if (lif_done || timeout) state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            data_q   <= '0;
            thr_q    <= '0;
            id_q     <= '0;
            spikes_q <= '0;
            err_q    <= 1'b0;
            job_q    <= '0;
            wd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= req_data[32'(gnt_idx) * T * Q +: T * Q];
                thr_q  <= cfg_threshold;
                id_q   <= gnt_idx;
            end
            if (state_q == StIssue) begin
                wd_q <= '0;
            end else if (state_q == StWait) begin
                wd_q <= wd_q + WdW'(1);
            end
            // A done coinciding with the timeout cycle still counts as a result.
            if (state_q == StWait && lif_done) begin
                spikes_q <= lif_spike_out;
                err_q    <= 1'b0;
            end else if (timeout) begin
                spikes_q <= '0;
                err_q    <= 1'b1;
            end
            if (rsp_fire) begin
                rr_ptr_q <= (id_q == IdW'(N - 1)) ? '0 : id_q + IdW'(1);
                job_q    <= job_q + 16'd1;
            end
        end
    end

    always_comb begin
        rsp_spike_cnt = '0;
        for (int unsigned i = 0; i < T; i++) begin
            rsp_spike_cnt = rsp_spike_cnt + CntW'(spikes_q[i]);
        end
    end

    assign lif_input_data = data_q;
    assign lif_threshold  = thr_q;
    assign rsp_id         = id_q;
    assign rsp_spikes     = spikes_q;
    assign rsp_err        = err_q;
    assign busy           = (state_q != StIdle);
    assign job_count      = job_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler with a behavioural integrate-and-fire stub
// standing in for the shared LIF unit.
module tb_lif_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned T = 4;
    localparam int unsigned Q = 8;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*T*Q-1:0] req_data;
    logic [Q-1:0]     cfg_threshold;
    logic             lif_start;
    logic             lif_result_val;
    logic [T*Q-1:0]   lif_input_data;
    logic [Q-1:0]     lif_threshold;
    logic [T-1:0]     lif_spike_out;
    logic             lif_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [T-1:0]     rsp_spikes;
    logic [2:0]       rsp_spike_cnt;
    logic             rsp_err;
    logic             busy;
    logic [15:0]      job_count;

    int total = 0;
    int bad = 0;
    int exp_jobs = 0;

    always #5 clk = ~clk;

    lif_scheduler #(
        .N       (N),
        .T       (T),
        .Q       (Q),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .cfg_threshold  (cfg_threshold),
        .lif_start      (lif_start),
        .lif_result_val (lif_result_val),
        .lif_input_data (lif_input_data),
        .lif_threshold  (lif_threshold),
        .lif_spike_out  (lif_spike_out),
        .lif_done       (lif_done),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_spikes     (rsp_spikes),
        .rsp_spike_cnt  (rsp_spike_cnt),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .job_count      (job_count)
    );

    // LIF stub: accumulate, fire and reset to zero at threshold, no leak.
    function automatic logic [T-1:0] lif_model(input logic [T*Q-1:0] d, input logic [Q-1:0] th);
        int v;
        logic [T-1:0] s;
        v = 0;
        s = '0;
        for (int t = 0; t < T; t++) begin
            v = v + int'(d[t*Q +: Q]);
            if (v >= int'(th)) begin
                s[t] = 1'b1;
                v = 0;
            end
        end
        return s;
    endfunction

    logic         stub_busy;
    logic [7:0]   stub_cnt;
    logic [T-1:0] stub_spk;
    logic         done_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy <= 1'b0;
            stub_cnt  <= '0;
            stub_spk  <= '0;
        end else if (lif_start) begin
            stub_busy <= 1'b1;
            stub_cnt  <= '0;
            stub_spk  <= lif_model(lif_input_data, lif_threshold);
        end else if (stub_busy) begin
            if (stub_cnt == 8'(T + 1)) stub_busy <= 1'b0;
            stub_cnt <= stub_cnt + 8'd1;
        end
    end

    // Start seen at the end of cycle 1, so done lands in cycle T+3.
    assign lif_done      = stub_busy && (stub_cnt == 8'(T + 1)) && done_en;
    assign lif_spike_out = stub_spk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [Q-1:0] v);
        req_data[ch*T*Q +: T*Q] = {T{v}};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        cfg_threshold = '0;
        req_data = '0;
        done_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({busy, lif_start, lif_result_val, rsp_valid, rsp_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, lif_start, lif_result_val, rsp_valid, rsp_err});
        end
        total++;
        if ({job_count, rsp_id, rsp_spikes, rsp_spike_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_rsp: job=%0h id=%0h spk=%b cnt=%0d want all 0",
                     job_count, rsp_id, rsp_spikes, rsp_spike_cnt);
        end
        total++;
        if ({lif_input_data, lif_threshold} !== '0) begin
            bad++;
            $display("FAIL reset_latch: data=%h thr=%h want 0", lif_input_data, lif_threshold);
        end
        tick();
        rst_n = 1'b1;
        exp_jobs = 0;
    endtask

    task automatic test_back_to_back();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [T-1:0] exp_spk[4] = '{4'b0100, 4'b1010, 4'b1111, 4'b0000};
        int ngrant = 0;
        int nrsp = 0;
        int last_g = 0;
        bit drop = 0;
        tick();
        set_data(0, 8'd5);
        set_data(1, 8'd10);
        set_data(2, 8'd15);
        set_data(3, 8'd3);
        cfg_threshold = 8'd15;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 70 && nrsp < 5; cyc++) begin
            if (req_ready !== 4'b0000) begin
                total++;
                if (ngrant >= 5 || req_ready !== (4'b0001 << exp_id[ngrant])) begin
                    bad++;
                    $display("FAIL b2b_grant%0d: got %b in cycle %0d", ngrant, req_ready, cyc);
                end
                if (ngrant > 0) begin
                    total++;
                    if (cyc - last_g != T + 5) begin
                        bad++;
                        $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_g, T + 5);
                    end
                end
                last_g = cyc;
                ngrant++;
                if (ngrant == 5) drop = 1;
            end
            if (rsp_valid === 1'b1) begin
                total++;
                if (rsp_id !== 2'(exp_id[nrsp]) || rsp_spikes !== exp_spk[exp_id[nrsp]]) begin
                    bad++;
                    $display("FAIL b2b_rsp%0d: got id=%0d spk=%b want id=%0d spk=%b", nrsp,
                             rsp_id, rsp_spikes, exp_id[nrsp], exp_spk[exp_id[nrsp]]);
                end
                nrsp++;
                exp_jobs++;
            end
            tick();
            if (drop) req_valid = '0;
            #1;
        end
        total++;
        if (nrsp != 5 || ngrant != 5) begin
            bad++;
            $display("FAIL b2b_count: got rsp=%0d grants=%0d want 5 and 5", nrsp, ngrant);
        end
        total++;
        if (job_count !== 16'(exp_jobs)) begin
            bad++;
            $display("FAIL b2b_jobs: got %0d want %0d", job_count, exp_jobs);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        tick();
        set_data(2, 8'd10);
        cfg_threshold = 8'd15;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        total++;
        if ({lif_start, lif_result_val, busy} !== 3'b111) begin
            bad++;
            $display("FAIL single_issue: got %b want 111", {lif_start, lif_result_val, busy});
        end
        tick();
        #1;
        total++;
        if (lif_start !== 1'b0) begin
            bad++;
            $display("FAIL single_start_pulse: got %b want 0", lif_start);
        end
        cyc = 2;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            #1;
            cyc++;
        end
        total++;
        if (cyc != 8) begin
            bad++;
            $display("FAIL single_latency: got cycle %0d want 8", cyc);
        end
        total++;
        if (rsp_id !== 2'd2 || rsp_spikes !== 4'b1010 || rsp_spike_cnt !== 3'd2 || rsp_err !== 1'b0)
        begin
            bad++;
            $display("FAIL single_rsp: got id=%0d spk=%b cnt=%0d err=%b want 2 1010 2 0",
                     rsp_id, rsp_spikes, rsp_spike_cnt, rsp_err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_jobs++;
        #1;
        total++;
        if (job_count !== 16'(exp_jobs) || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got job=%0d busy=%b valid=%b want %0d 0 0",
                     job_count, busy, rsp_valid, exp_jobs);
        end
    endtask

    task automatic test_stall();
        int cyc;
        tick();
        set_data(1, 8'd10);
        cfg_threshold = 8'd15;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL stall_ready: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            #1;
            cyc++;
        end
        req_valid = 4'b1001;
        #1;
        for (int s = 0; s < 5; s++) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_spikes, req_ready, lif_start} !== {1'b1, 2'd1, 4'b1010,
                4'b0000, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b id=%0d spk=%b rdy=%b st=%b want 1 1 1010 0000 0",
                         s, rsp_valid, rsp_id, rsp_spikes, req_ready, lif_start);
            end
            tick();
            #1;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_jobs++;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL stall_next_grant: got %b want 1000", req_ready);
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            #1;
            cyc++;
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_spikes !== 4'b0000) begin
            bad++;
            $display("FAIL stall_drain: got v=%b id=%0d spk=%b want 1 3 0000",
                     rsp_valid, rsp_id, rsp_spikes);
        end
        tick();
        rsp_ready = 1'b0;
        exp_jobs++;
    endtask

    task automatic test_threshold();
        int cyc;
        logic [T-1:0] exp_spk[2] = '{4'b1111, 4'b1010};
        logic [Q-1:0] exp_thr[2] = '{8'd15, 8'd200};
        set_data(0, 8'd100);
        cfg_threshold = 8'd15;
        for (int j = 0; j < 2; j++) begin
            tick();
            req_valid = 4'b0001;
            #1;
            total++;
            if (req_ready !== 4'b0001) begin
                bad++;
                $display("FAIL thr_ready%0d: got %b want 0001", j, req_ready);
            end
            tick();
            req_valid = '0;
            tick();
            cfg_threshold = 8'd200;
            #1;
            total++;
            if (lif_threshold !== exp_thr[j]) begin
                bad++;
                $display("FAIL thr_latched%0d: got %0d want %0d", j, lif_threshold, exp_thr[j]);
            end
            cyc = 0;
            while (rsp_valid !== 1'b1 && cyc < 40) begin
                tick();
                #1;
                cyc++;
            end
            total++;
            if (rsp_valid !== 1'b1 || rsp_spikes !== exp_spk[j]) begin
                bad++;
                $display("FAIL thr_spikes%0d: got v=%b spk=%b want 1 %b",
                         j, rsp_valid, rsp_spikes, exp_spk[j]);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            exp_jobs++;
        end
    endtask

    task automatic test_timeout();
        int cyc;
        done_en = 1'b0;
        tick();
        set_data(2, 8'd10);
        cfg_threshold = 8'd15;
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        #1;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 120) begin
            tick();
            #1;
            cyc++;
        end
        total++;
        if (cyc != TIMEOUT + 2) begin
            bad++;
            $display("FAIL to_latency: got cycle %0d want %0d", cyc, TIMEOUT + 2);
        end
        total++;
        if (rsp_err !== 1'b1 || rsp_spikes !== 4'b0000 || rsp_spike_cnt !== 3'd0 || rsp_id !== 2'd2)
        begin
            bad++;
            $display("FAIL to_rsp: got err=%b spk=%b cnt=%0d id=%0d want 1 0000 0 2",
                     rsp_err, rsp_spikes, rsp_spike_cnt, rsp_id);
        end
        total++;
        if (lif_input_data !== {4{8'd10}}) begin
            bad++;
            $display("FAIL to_data_hold: got %h want 0a0a0a0a", lif_input_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_jobs++;
        #1;
        total++;
        if (job_count !== 16'(exp_jobs)) begin
            bad++;
            $display("FAIL to_jobs: got %0d want %0d", job_count, exp_jobs);
        end
        done_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int cyc;
        tick();
        set_data(1, 8'd50);
        cfg_threshold = 8'd77;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, lif_start, rsp_valid, rsp_err} !== 4'b0 || job_count !== 16'd0) begin
            bad++;
            $display("FAIL rstmid_flags: got busy=%b st=%b v=%b err=%b job=%0d want all 0",
                     busy, lif_start, rsp_valid, rsp_err, job_count);
        end
        total++;
        if ({lif_input_data, lif_threshold, rsp_id, rsp_spikes} !== '0) begin
            bad++;
            $display("FAIL rstmid_latch: got data=%h thr=%h id=%0d spk=%b want 0",
                     lif_input_data, lif_threshold, rsp_id, rsp_spikes);
        end
        tick();
        rst_n = 1'b1;
        exp_jobs = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            #1;
            if (rsp_valid !== 1'b0 || lif_start !== 1'b0) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rstmid_no_rsp: got activity after reset want none");
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            #1;
            cyc++;
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_rsp: got v=%b id=%0d want 1 0", rsp_valid, rsp_id);
        end
        tick();
        rsp_ready = 1'b0;
        exp_jobs++;
        #1;
        total++;
        if (job_count !== 16'(exp_jobs)) begin
            bad++;
            $display("FAIL rstmid_jobs: got %0d want %0d", job_count, exp_jobs);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_stall();
        test_threshold();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
